// File: rtl/button_event_pkg.sv
// ============================================================================
// Module   : button_event_pkg
// Brief    : Shared state encoding and counter sizing for button_event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_event_pkg;

  // Event FSM states; LOCKOUT is the reset state.
  typedef enum logic [1:0] {
    LOCKOUT   = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    LONG_HELD = 2'd3
  } btn_state_t;

  // Hold/repeat counter width: clog2 of the larger threshold. The repeat
  // period only matters when the repeat feature is built in. The span is
  // floored at 2 so the counter is never narrower than one bit.
  function automatic int cnt_width(input int long_cycles,
                                   input int repeat_cycles,
                                   input bit repeat_en);
    int span;
    span = long_cycles;
    if (repeat_en && (repeat_cycles > span)) span = repeat_cycles;
    if (span < 2) span = 2;
    return $clog2(span);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event.sv
// ============================================================================
// Module   : button_event
// Brief    : Turns a debounced button level into single-cycle events:
//            press, release_short, long_press, release_long and optional
//            auto-repeat ticks. One instance per button.
// Config   : BUTTON_EVENT_REPEAT_EN - when defined, LONG_HELD produces
//            repeat_tick every REPEAT_CYCLES; otherwise repeat_tick is 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES     = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press,
  output logic release_short,
  output logic long_press,
  output logic release_long,
  output logic repeat_tick,
  output logic held
);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, REPEAT_CYCLES, REPEAT_EN);

  // Last counter value before the long-press threshold is reached.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  // Last counter value of one repeat period.
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_short_q, release_short_d;
  logic             long_press_q, long_press_d;
  logic             release_long_q, release_long_d;
  logic             repeat_tick_q, repeat_tick_d;
  logic             held_q, held_d;

  // Next-state, counter and event decode; release always takes priority
  // over a threshold hit landing in the same cycle.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_d         = 1'b0;
    release_short_d = 1'b0;
    long_press_d    = 1'b0;
    release_long_d  = 1'b0;
    repeat_tick_d   = 1'b0;

    case (state_q)
      LOCKOUT: begin
        // A button held through reset stays silent until it is released.
        if (!level) state_d = IDLE;
      end
      IDLE: begin
        if (level) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!level) begin
          state_d         = IDLE;
          release_short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = LONG_HELD;
          long_press_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!level) begin
          state_d        = IDLE;
          release_long_d = 1'b1;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (cnt_q == REPEAT_LAST) begin
            repeat_tick_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: state_d = LOCKOUT;
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  // State, counter and registered outputs; reset lands in LOCKOUT with
  // every output low and no release event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOCKOUT;
      cnt_q           <= '0;
      press_q         <= 1'b0;
      release_short_q <= 1'b0;
      long_press_q    <= 1'b0;
      release_long_q  <= 1'b0;
      repeat_tick_q   <= 1'b0;
      held_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_q         <= press_d;
      release_short_q <= release_short_d;
      long_press_q    <= long_press_d;
      release_long_q  <= release_long_d;
      repeat_tick_q   <= repeat_tick_d;
      held_q          <= held_d;
    end
  end

  assign press         = press_q;
  assign release_short = release_short_q;
  assign long_press    = long_press_q;
  assign release_long  = release_long_q;
  assign repeat_tick   = repeat_tick_q;
  assign held          = held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
// ============================================================================
// Module   : tb_button_event
// Brief    : Directed self-checking bench for button_event with
//            LONG_PRESS_CYCLES = 8 and REPEAT_CYCLES = 4. Expected repeat
//            ticks follow BUTTON_EVENT_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event;

  localparam int LONG_PRESS_CYCLES = 8;
  localparam int REPEAT_CYCLES     = 4;

  // Output vector layout: {press, release_short, long_press, release_long,
  //                        repeat_tick, held}
  localparam logic [5:0] C_Z  = 6'b000000;
  localparam logic [5:0] C_P  = 6'b100001;
  localparam logic [5:0] C_RS = 6'b010000;
  localparam logic [5:0] C_LP = 6'b001001;
  localparam logic [5:0] C_RL = 6'b000100;
  localparam logic [5:0] C_RT = 6'b000011;
  localparam logic [5:0] C_H  = 6'b000001;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [5:0] C_TICK = C_RT;
`else
  localparam logic [5:0] C_TICK = C_H;
`endif

  logic clk;
  logic rst_n;
  logic level;
  logic press;
  logic release_short;
  logic long_press;
  logic release_long;
  logic repeat_tick;
  logic held;

  int n_assert;
  int n_fail;

  button_event #(
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
    .REPEAT_CYCLES    (REPEAT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .level        (level),
    .press        (press),
    .release_short(release_short),
    .long_press   (long_press),
    .release_long (release_long),
    .repeat_tick  (repeat_tick),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive level for one clock edge, then settle 1 ns past the edge.
  task automatic step(input logic lv);
    level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {press, release_short, long_press, release_long, repeat_tick, held};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    level    = 1'b1;
    rst_n    = 1'b0;

    // Reset with the button held: outputs zero, no events until released.
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", C_Z);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      check($sformatf("lockout_hold_%0d", i), C_Z);
    end
    step(1'b0);
    check("lockout_release", C_Z);
    step(1'b1);
    check("after_lockout_press", C_P);
    step(1'b0);
    check("after_lockout_release", C_RS);
    step(1'b0);
    check("after_lockout_idle", C_Z);

    // Three-cycle press: press, held, held, release_short.
    step(1'b1); check("short_press", C_P);
    step(1'b1); check("short_held_1", C_H);
    step(1'b1); check("short_held_2", C_H);
    step(1'b0); check("short_release", C_RS);
    step(1'b0); check("short_idle", C_Z);

    // One-cycle pulse: press then release_short on the next cycle.
    step(1'b1); check("pulse_press", C_P);
    step(1'b0); check("pulse_release", C_RS);
    step(1'b0); check("pulse_idle", C_Z);

    // 20-cycle hold: long_press 8 cycles after press, ticks every 4,
    // and a release that coincides with a tick suppresses that tick.
    for (int i = 0; i < 20; i++) begin
      logic [5:0] e;
      step(1'b1);
      if (i == 0)                 e = C_P;
      else if (i < 8)             e = C_H;
      else if (i == 8)            e = C_LP;
      else if (i == 12 || i == 16) e = C_TICK;
      else                        e = C_H;
      check($sformatf("long_hold_%0d", i), e);
    end
    step(1'b0); check("long_release", C_RL);
    step(1'b0); check("long_idle", C_Z);

    // Release exactly when the counter sits at the threshold: short wins.
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check($sformatf("edge_hold_%0d", i), (i == 0) ? C_P : C_H);
    end
    step(1'b0); check("edge_release_short", C_RS);
    step(1'b0); check("edge_idle", C_Z);

    // Reset during LONG_HELD: immediate clear, no release_long, lockout.
    for (int i = 0; i < 10; i++) step(1'b1);
    check("pre_reset_long_held", C_H);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", C_Z);
    step(1'b1);
    check("reset_held_low", C_Z);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check($sformatf("post_reset_hold_%0d", i), C_Z);
    end
    step(1'b0); check("post_reset_release", C_Z);
    step(1'b1); check("post_reset_press", C_P);
    step(1'b0); check("post_reset_short", C_RS);
    step(1'b0); check("post_reset_idle", C_Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event.md
# button_event

Converts the clean, synchronous button level produced by the input debouncer into discrete user events: press, short release, long press, long release, and (optionally) auto-repeat ticks. It sits between the per-button debouncer and the stopwatch control FSM. Control logic therefore consumes single-cycle event pulses instead of raw levels. One instance is used per button.

## Interface
- `LONG_PRESS_CYCLES`, default 100_000_000, is the number of clock cycles a press must be held to count as long (1 s at 100 MHz). Legal values are ≥ 2.
- `REPEAT_CYCLES`, default 20_000_000, is the period of auto-repeat ticks once a long press is reached. Legal values are ≥ 2.
- `clk`, in, 1: the system clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `level`, in, 1: debounced button level, already synchronous to `clk`. 1 means pressed.
- `press`, out, 1: one-cycle pulse on accepted press.
- `release_short`, out, 1: one-cycle pulse on release before the long threshold.
- `long_press`, out, 1: one-cycle pulse when the hold reaches `LONG_PRESS_CYCLES`.
- `release_long`, out, 1: one-cycle pulse on release after `long_press` fired.
- `repeat_tick`, out, 1: one-cycle pulse every `REPEAT_CYCLES` while long-held.
- `held`, out, 1: high while in PRESSED or LONG_HELD.

## Operation
- The FSM has four states: LOCKOUT, IDLE, PRESSED and LONG_HELD. The reset state is LOCKOUT.
- LOCKOUT → IDLE when `level` = 0 is sampled. A button held through reset generates no events until it has been released.
- IDLE → PRESSED when `level` = 1. `press` fires and the counter clears to 0.
- In PRESSED the counter increments every cycle while `level` = 1.
  - When `level` = 0: `release_short` fires and the FSM returns to IDLE.
  - When the counter = `LONG_PRESS_CYCLES`−1 and `level` = 1: `long_press` fires, the FSM moves to LONG_HELD and the counter clears.
- In LONG_HELD:
  - When `level` = 0: `release_long` fires and the FSM returns to IDLE.
  - Otherwise, if the repeat feature is compiled in, the counter increments. `repeat_tick` fires when the counter = `REPEAT_CYCLES`−1, and the counter then wraps to 0.
- Simultaneous events: if release and a threshold hit land in the same cycle, release wins. In PRESSED this gives `release_short` with no `long_press`. In LONG_HELD it gives `release_long` with no `repeat_tick`.
- The counter width is $clog2(max(`LONG_PRESS_CYCLES`, `REPEAT_CYCLES`)). Because the counter clears on every state entry, it never overflows.
- All event pulses are mutually exclusive. At most one event output is high in any cycle.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency is one cycle from the `clk` edge that samples a `level` change to the corresponding pulse going high. Each pulse is exactly one cycle wide.
- `long_press` asserts exactly `LONG_PRESS_CYCLES` cycles after `press` asserts.
- The first `repeat_tick` asserts `REPEAT_CYCLES` cycles after `long_press`. Later ticks are spaced `REPEAT_CYCLES` cycles apart.
- `held` rises in the same cycle as `press`. It falls in the same cycle as `release_short` or `release_long`.
- A one-cycle `level` pulse (1 then 0) produces `press` followed by `release_short` on the next cycle.
- Asserting `rst_n` mid-operation immediately forces all outputs to 0 and the FSM to LOCKOUT. No release event is generated.

## Configuration
- Macro: `BUTTON_EVENT_REPEAT_EN`.
- When defined, LONG_HELD runs the repeat counter and `repeat_tick` is generated as described above.
- When undefined, `repeat_tick` is tied to 0, the counter holds at 0 in LONG_HELD, and `REPEAT_CYCLES` is ignored in the counter-width calculation. All other behaviour is unchanged.

## Structure
- Package `button_event_pkg` holds:
  - the `btn_state_t` enum (LOCKOUT, IDLE, PRESSED, LONG_HELD);
  - a constant function that computes the counter width from the two parameters.
- The block is a single module with no sub-module. The edge and threshold logic is too small to split out.

## Test plan
Parameters for all tests: `LONG_PRESS_CYCLES` = 8, `REPEAT_CYCLES` = 4.
- Reset with `level` = 1, release `rst_n`, hold `level` high 20 cycles, then drop it → no outputs at all. Raise `level` again → `press` on the next cycle.
- Raise `level` for 3 cycles, then drop it → `press` at t+1, `release_short` at t+4, `held` high for t+1..t+3.
- Hold `level` for 20 cycles with the repeat macro defined → `press` at t+1, `long_press` at t+9, `repeat_tick` at t+13 and t+17, `release_long` one cycle after the drop.
- Same as the previous test with the macro undefined → `repeat_tick` never asserts. `long_press` and `release_long` timing is identical.
- Drop `level` on exactly the cycle where the counter = 7 → `release_short` fires and `long_press` never fires.
- Assert `rst_n` low during LONG_HELD → all outputs go to 0 immediately, with no `release_long`. After deassertion, a `level` held at 1 generates nothing until it has gone to 0.
